// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: shares the TX FSM between the LTSM requester, the remote-response requester and the start pattern.
// A request seen in IDLE gives o_msg_valid two cycles later; define SB_ARB_TIMEOUT_EN to enable the busy/pattern watchdog.
module sb_tx_arbiter #(
  parameter int MSG_W          = 64,
  parameter int GUARD_CYCLES   = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic [MSG_W-1:0] i_req0_msg,
  input  logic             i_req0_has_data,
  output logic             o_req0_done,
  input  logic             i_req1_valid,
  input  logic [MSG_W-1:0] i_req1_msg,
  input  logic             i_req1_has_data,
  output logic             o_req1_done,
  input  logic             i_pattern_req,
  input  logic             i_pattern_done,
  output logic             o_start_pattern_req,
  output logic             o_msg_valid,
  output logic             o_data_valid,
  output logic [MSG_W-1:0] o_msg,
  output logic [1:0]       o_grant,
  output logic             o_timeout_err,
  input  logic             i_tx_busy
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);

  if (GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sb_tx_arbiter: GUARD_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_PATTERN, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GUARD
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic              has_data_q, has_data_d;
  logic              last_q, last_d;
  logic              pat_q, pat_d;
  logic              msg_vld_q, msg_vld_d;
  logic              data_vld_q, data_vld_d;
  logic [1:0]        done_q, done_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              wd_hit;
  logic              pick1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    msg_d      = msg_q;
    has_data_d = has_data_q;
    last_d     = last_q;
    pat_d      = pat_q;
    gcnt_d     = gcnt_q;
    msg_vld_d  = 1'b0;
    data_vld_d = 1'b0;
    done_d     = 2'b00;
    // last_q=1 means req1 was granted last, so req0 wins the next tie
    pick1      = i_req1_valid && (!i_req0_valid || !last_q);
    case (state_q)
      S_IDLE: begin
        if (i_pattern_req) begin
          pat_d   = 1'b1;
          state_d = S_PATTERN;
        end else if (i_req0_valid || i_req1_valid) begin
          grant_d    = pick1 ? 2'b10 : 2'b01;
          msg_d      = pick1 ? i_req1_msg : i_req0_msg;
          has_data_d = pick1 ? i_req1_has_data : i_req0_has_data;
          last_d     = pick1;
          state_d    = S_ISSUE;
        end
      end
      S_PATTERN: begin
        if (i_pattern_done || wd_hit) begin
          pat_d   = 1'b0;
          gcnt_d  = '0;
          state_d = S_GUARD;
        end
      end
      S_ISSUE: begin
        msg_vld_d  = 1'b1;
        data_vld_d = has_data_q;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (wd_hit) begin
          done_d  = grant_q;
          grant_d = 2'b00;
          gcnt_d  = '0;
          state_d = S_GUARD;
        end else if (i_tx_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy || wd_hit) begin
          done_d  = grant_q;
          grant_d = 2'b00;
          gcnt_d  = '0;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        if (gcnt_q == GW'(GUARD_CYCLES - 1)) state_d = S_IDLE;
        else                                  gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      msg_q      <= '0;
      has_data_q <= 1'b0;
      last_q     <= 1'b1;
      pat_q      <= 1'b0;
      msg_vld_q  <= 1'b0;
      data_vld_q <= 1'b0;
      done_q     <= 2'b00;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      msg_q      <= msg_d;
      has_data_q <= has_data_d;
      last_q     <= last_d;
      pat_q      <= pat_d;
      msg_vld_q  <= msg_vld_d;
      data_vld_q <= data_vld_d;
      done_q     <= done_d;
      gcnt_q     <= gcnt_d;
    end
  end

`ifdef SB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          wd_run, tmo_q, tmo_d;

  always_comb begin
    wd_run = (state_q == S_PATTERN) || (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    wd_hit = wd_run && (wd_q == TW'(TIMEOUT_CYCLES - 1));
    wd_d   = '0;
    if (wd_run && !wd_hit) wd_d = wd_q + 1'b1;
    // a normal completion in the expiry cycle wins over the error
    tmo_d  = wd_hit && !((state_q == S_WAIT_DONE) && !i_tx_busy)
                    && !((state_q == S_PATTERN) && i_pattern_done);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign o_timeout_err = tmo_q;
`else
  assign wd_hit        = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign o_grant             = grant_q;
  assign o_msg               = msg_q;
  assign o_start_pattern_req = pat_q;
  assign o_msg_valid         = msg_vld_q;
  assign o_data_valid        = data_vld_q;
  assign o_req0_done         = done_q[0];
  assign o_req1_done         = done_q[1];

endmodule

// File: doc/sb_tx_arbiter.md
Name: sb_tx_arbiter

Overview:
Sequences the sideband TX path by sharing it between two message requesters and the start-pattern request. Requester 0 is the LTSM request path; requester 1 is the remote-response path. Sits directly upstream of the sideband TX FSM and drives its start-pattern request, message-valid and data-valid inputs. Enforces one-message-at-a-time ownership, including the TX FSM's post-message idle tail.

Parameters:
MSG_W, 64, width of the message/header payload passed through to the encoders.
GUARD_CYCLES, 6, idle cycles inserted after TX busy falls (or pattern done) before the next issue; must be >= 1.
TIMEOUT_CYCLES, 255, watchdog limit used only when SB_ARB_TIMEOUT_EN is defined.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_req0_valid  in  1  requester 0 (LTSM) message pending; held until o_req0_done
i_req0_msg  in  MSG_W  requester 0 message; stable while valid
i_req0_has_data  in  1  requester 0 message carries a data payload
o_req0_done  out  1  1-cycle pulse: requester 0 message completed (or dropped)
i_req1_valid  in  1  requester 1 (response) message pending
i_req1_msg  in  MSG_W  requester 1 message
i_req1_has_data  in  1  requester 1 message carries a data payload
o_req1_done  out  1  1-cycle pulse: requester 1 message completed (or dropped)
i_pattern_req  in  1  start-pattern request; level, held until i_pattern_done
i_pattern_done  in  1  pattern generator completion pulse
o_start_pattern_req  out  1  to TX FSM; level, held through pattern
o_msg_valid  out  1  to TX FSM; 1-cycle pulse per issued message
o_data_valid  out  1  to TX FSM; coincident with o_msg_valid when the granted message has data
o_msg  out  MSG_W  muxed message of the granted requester; held from issue to done
o_grant  out  2  one-hot owner (bit0 = req0, bit1 = req1); 0 when idle or in pattern
o_timeout_err  out  1  1-cycle pulse on watchdog expiry
i_tx_busy  in  1  TX FSM busy

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; round-robin pointer set so req0 wins the first tie; guard and watchdog counters cleared. Reset mid-transfer aborts silently; no done pulse.
- States: IDLE, PATTERN, ISSUE, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE priority: i_pattern_req, then message requests.
  - Pattern wins: o_start_pattern_req=1 next cycle; go to PATTERN.
  - Otherwise, if exactly one requester is valid, grant it.
  - If both are valid, grant the one not granted last (round robin); pointer updates on grant.
  - On grant: latch o_grant and o_msg; go to ISSUE.
- PATTERN: no message is ever issued, because a message-valid aborts the TX FSM pattern. On i_pattern_done, o_start_pattern_req=0 next cycle; go to GUARD.
- ISSUE (exactly 1 cycle): o_msg_valid=1; o_data_valid = latched has_data. Go to WAIT_BUSY.
- WAIT_BUSY: wait for i_tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: on i_tx_busy falling to 0:
  - pulse the owner's o_reqN_done for 1 cycle;
  - clear o_grant;
  - go to GUARD.
- GUARD: count GUARD_CYCLES cycles, then IDLE. A request arriving during GUARD is evaluated in IDLE, so there is no same-cycle bypass.
- Latency: request in IDLE to o_msg_valid = 2 cycles (grant cycle, then ISSUE).
- Requester rules:
  - Deasserting valid after grant does not cancel; done is still pulsed.
  - Valid asserted in the cycle its done pulses is treated as a new request.
- Simultaneous i_pattern_req with both requesters valid: pattern first, then round robin resumes with the pointer unchanged.
- Counters saturate; no wrap-around.

Optional Feature:
SB_ARB_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles spent in WAIT_BUSY+WAIT_DONE (one run per message) and in PATTERN.
  - On reaching TIMEOUT_CYCLES: pulse o_timeout_err; pulse the owner's done (message dropped), or drop o_start_pattern_req (pattern case); go to GUARD.
- Not defined:
  - o_timeout_err is tied to 0 and the watchdog logic is absent.
  - The arbiter waits indefinitely for i_tx_busy / i_pattern_done.

Test Plan:
1. req0 only, has_data=1; TX busy high 3 cycles after issue, low 4 cycles later -> o_msg_valid and o_data_valid pulse 2 cycles after req; o_req0_done pulses when busy falls; next grant no earlier than 6+1 cycles later.
2. req0 and req1 valid together, held for 4 messages -> grant order 0,1,0,1; o_msg matches owner each time.
3. i_pattern_req and req1 asserted in the same cycle -> o_start_pattern_req=1, no o_msg_valid until i_pattern_done; then GUARD, then req1 issued.
4. Reset asserted in WAIT_DONE -> all outputs 0 immediately (async); no done pulse; after release, req0 wins a tie.
5. SB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20, i_tx_busy never rises -> o_timeout_err and o_req0_done pulse together 20 cycles after issue; arbiter then recovers and serves req1.
6. Without SB_ARB_TIMEOUT_EN, same stimulus -> arbiter stays in WAIT_BUSY; o_timeout_err stays 0.
